// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 16-byte blocks, zero-cycle hits.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module instruction_cache #(
  parameter int TAG_BITS   = 3,
  parameter int INDEX_BITS = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [31:0]                    address,
  output logic [31:0]                    instruction,
  output logic                           busywait,
  output logic                           mem_read,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
  input  logic [127:0]                   mem_readdata,
  input  logic                           mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count
`endif
);

  localparam int AW    = TAG_BITS + INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_READ = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;

  logic [1:0]          state;
  logic [127:0]        data_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINES-1:0]    valid;
  logic [AW-1:0]       miss_addr;
  logic [127:0]        fill;

  logic [1:0]            word;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic                  request;
  logic                  hit;
  logic                  lookup;
  logic [127:0]          blk;

  assign word       = address[3:2];
  assign index      = address[INDEX_BITS+3:4];
  assign tag        = address[AW+3:INDEX_BITS+4];
  assign fill_index = miss_addr[INDEX_BITS-1:0];

  // Bit 31 set is the PC-stage reset sentinel, meaning no fetch this cycle.
  assign request = !address[31];
  assign hit     = valid[index] && (tag_mem[index] == tag);
  assign lookup  = !RESET && (state == S_IDLE) && request;
  assign blk     = data_mem[index];

  logic unused;
  assign unused = ^{address[30:AW+4], address[1:0]};

  always_comb begin
    busywait    = 1'b0;
    instruction = 32'd0;
    if (!RESET) begin
      unique case (state)
        S_IDLE: begin
          if (request) begin
            if (hit) instruction = blk[{word, 5'b0} +: 32];
            else     busywait    = 1'b1;
          end
        end
        default: busywait = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      valid       <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      miss_addr   <= '0;
      fill        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (request && !hit) begin
            state       <= S_MEM_READ;
            miss_addr   <= {tag, index};
            mem_read    <= 1'b1;
            mem_address <= {tag, index};
          end
        end
        S_MEM_READ: begin
          if (!mem_busywait) begin
            fill        <= mem_readdata;
            state       <= S_UPDATE;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end
        S_UPDATE: begin
          valid[fill_index] <= 1'b1;
          state             <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays are never cleared; valid bits gate them.
  always_ff @(posedge CLK) begin
    if (!RESET && state == S_UPDATE) begin
      data_mem[fill_index] <= fill;
      tag_mem[fill_index]  <= miss_addr[AW-1:INDEX_BITS];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (lookup && hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (lookup && !hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache against a line-level reference model.
// Define ICACHE_STATS_EN to also exercise the hit/miss counters.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instruction_cache dut (
    .CLK(CLK),
    .RESET(RESET),
    .address(address),
    .instruction(instruction),
    .busywait(busywait),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int lat   = 3;
  int cnt   = 0;

  localparam logic [31:0] NOREQ = 32'hFFFF_FFFC;

  // Backing memory: word w of block b.
  function automatic logic [31:0] mem_word(input logic [5:0] b, input int w);
    return (32'h1111_1111 * (w + 1)) ^ {6'b0, b, 20'b0};
  endfunction

  assign mem_readdata = {mem_word(mem_address, 3), mem_word(mem_address, 2),
                         mem_word(mem_address, 1), mem_word(mem_address, 0)};
  // Data ready on the lat-th cycle that mem_read is held high.
  assign mem_busywait = !(mem_read && cnt == lat - 1);

  always @(posedge CLK) begin
    if (mem_read && mem_busywait) cnt <= cnt + 1;
    else                          cnt <= 0;
  end

  // Reference model: which block each line currently holds.
  bit       ref_valid [8];
  bit [2:0] ref_tag   [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET   = 1'b1;
    address = NOREQ;
    @(negedge CLK);
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input logic [31:0] a, output int stalls,
                       output logic [31:0] ins, output int rd_cycles,
                       output logic [5:0] rd_addr);
    @(negedge CLK);
    address = a;
    #1;
    stalls    = 0;
    rd_cycles = 0;
    rd_addr   = '0;
    while (busywait === 1'b1 && stalls < 100) begin
      if (mem_read === 1'b1) begin
        rd_cycles++;
        rd_addr = mem_address;
      end
      @(negedge CLK);
      #1;
      stalls++;
    end
    ins = instruction;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET   = 1'b1;
    address = NOREQ;
    #1;
    total++;
    if (busywait !== 1'b0 || instruction !== 32'd0) begin
      bad++;
      $display("FAIL reset_hold busywait=%b instr=%h want 0/0", busywait, instruction);
    end
    @(negedge CLK);
    RESET = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (busywait !== 1'b0 || instruction !== 32'd0 ||
          mem_read !== 1'b0 || mem_address !== 6'd0) begin
        bad++;
        $display("FAIL reset_idle%0d bw=%b ins=%h rd=%b ma=%h want 0", i,
                 busywait, instruction, mem_read, mem_address);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_cold_miss();
    int st, rc;
    logic [31:0] ins;
    logic [5:0]  ra;
    lat = 3;
    fetch(32'h0, st, ins, rc, ra);
    total++;
    if (st != 5 || rc != 3 || ra !== 6'h00) begin
      bad++;
      $display("FAIL cold_miss stalls=%0d rdcyc=%0d maddr=%h want 5/3/00", st, rc, ra);
    end
    total++;
    if (ins !== 32'h1111_1111) begin
      bad++;
      $display("FAIL cold_miss_data got=%h want 11111111", ins);
    end
    ref_valid[0] = 1'b1;
    ref_tag[0]   = 3'd0;
  endtask

  task automatic test_hits();
    int st, rc;
    logic [31:0] ins;
    logic [5:0]  ra;
    logic [31:0] want [3];
    want[0] = 32'h2222_2222;
    want[1] = 32'h3333_3333;
    want[2] = 32'h4444_4444;
    for (int i = 0; i < 3; i++) begin
      fetch(32'(4 * (i + 1)), st, ins, rc, ra);
      total++;
      if (st != 0 || rc != 0 || mem_read !== 1'b0 || ins !== want[i]) begin
        bad++;
        $display("FAIL hit%0d stalls=%0d rd=%b ins=%h want 0/0/%h",
                 i, st, mem_read, ins, want[i]);
      end
    end
  endtask

  task automatic test_conflict();
    int st, rc;
    logic [31:0] ins;
    logic [5:0]  ra;
    lat = 2;
    fetch(32'h80, st, ins, rc, ra);
    total++;
    if (st != 4 || ra !== 6'h08 || ins !== mem_word(6'h08, 0)) begin
      bad++;
      $display("FAIL conflict_a stalls=%0d maddr=%h ins=%h want 4/08/%h",
               st, ra, ins, mem_word(6'h08, 0));
    end
    fetch(32'h0, st, ins, rc, ra);
    total++;
    if (st != 4 || ra !== 6'h00 || ins !== 32'h1111_1111) begin
      bad++;
      $display("FAIL conflict_b stalls=%0d maddr=%h ins=%h want 4/00/11111111",
               st, ra, ins);
    end
    ref_valid[0] = 1'b1;
    ref_tag[0]   = 3'd0;
  endtask

  task automatic test_noreq();
    int st, rc;
    logic [31:0] ins;
    logic [5:0]  ra;
    fetch(NOREQ, st, ins, rc, ra);
    repeat (2) @(negedge CLK);
    #1;
    total++;
    if (st != 0 || ins !== 32'd0 || mem_read !== 1'b0 || busywait !== 1'b0) begin
      bad++;
      $display("FAIL noreq stalls=%0d ins=%h rd=%b bw=%b want 0", st, ins,
               mem_read, busywait);
    end
  endtask

  task automatic test_reset_abort();
    int st, rc;
    logic [31:0] ins;
    logic [5:0]  ra;
    do_reset();
    lat = 3;
    @(negedge CLK);
    address = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_address !== 6'h04) begin
      bad++;
      $display("FAIL abort_pre rd=%b maddr=%h want 1/04", mem_read, mem_address);
    end
    RESET   = 1'b1;
    address = NOREQ;
    @(negedge CLK);
    #1;
    total++;
    if (mem_read !== 1'b0 || mem_address !== 6'h00 || busywait !== 1'b0) begin
      bad++;
      $display("FAIL abort_post rd=%b maddr=%h bw=%b want 0/00/0",
               mem_read, mem_address, busywait);
    end
    RESET = 1'b0;
    model_clear();
    fetch(32'h40, st, ins, rc, ra);
    total++;
    if (st != 5 || ra !== 6'h04 || ins !== mem_word(6'h04, 0)) begin
      bad++;
      $display("FAIL abort_refetch stalls=%0d maddr=%h ins=%h want 5/04/%h",
               st, ra, ins, mem_word(6'h04, 0));
    end
    ref_valid[4] = 1'b1;
    ref_tag[4]   = 3'd0;
  endtask

  task automatic test_random();
    int st, rc, w, exp_st;
    logic [31:0] a, ins, exp_ins;
    logic [5:0]  ra;
    logic [2:0]  idx, tg;
    for (int n = 0; n < 80; n++) begin
      lat = int'($urandom_range(1, 4));
      a   = {1'b0, 21'($urandom), 3'($urandom_range(0, 1)), 3'($urandom),
             2'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) a = NOREQ;
      fetch(a, st, ins, rc, ra);
      if (a[31]) begin
        exp_st  = 0;
        exp_ins = 32'd0;
      end else begin
        idx     = a[6:4];
        tg      = a[9:7];
        w       = int'(a[3:2]);
        exp_ins = mem_word({tg, idx}, w);
        if (ref_valid[idx] && ref_tag[idx] == tg) begin
          exp_st = 0;
        end else begin
          exp_st = lat + 2;
          total++;
          if (ra !== {tg, idx} || rc != lat) begin
            bad++;
            $display("FAIL rand%0d_fill addr=%h maddr=%h rdcyc=%0d want %h/%0d",
                     n, a, ra, rc, {tg, idx}, lat);
          end
          ref_valid[idx] = 1'b1;
          ref_tag[idx]   = tg;
        end
      end
      total++;
      if (st != exp_st || ins !== exp_ins) begin
        bad++;
        $display("FAIL rand%0d addr=%h stalls=%0d ins=%h want %0d/%h",
                 n, a, st, ins, exp_st, exp_ins);
      end
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    total++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      bad++;
      $display("FAIL stats_reset hits=%0d misses=%0d want 0/0", hit_count, miss_count);
    end
    test_cold_miss();
    test_hits();
    @(negedge CLK);
    address = NOREQ;
    repeat (2) @(negedge CLK);
    total++;
    if (hit_count !== 16'd4 || miss_count !== 16'd1) begin
      bad++;
      $display("FAIL stats hits=%0d misses=%0d want 4/1", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    RESET   = 1'b0;
    address = NOREQ;
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_noreq();
    test_reset_abort();
    test_random();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
